// File: rtl/ex_stage_pkg.sv
// Shared constants for the MIPS32 execute stage: bus widths, aluop/alusel codes,
// accumulate FSM state type and a leading-zero counter helper.
package ex_stage_pkg;

    localparam int RegBus     = 32;
    localparam int RegAddrBus = 5;
    localparam int AluOpBus   = 8;
    localparam int AluSelBus  = 3;

    localparam logic              RstEnable    = 1'b1;
    localparam logic              WriteEnable  = 1'b1;
    localparam logic              WriteDisable = 1'b0;
    localparam logic [RegBus-1:0] ZeroWord     = 32'h0000_0000;

    localparam logic [AluOpBus-1:0] EXE_NOP_OP   = 8'b0000_0000;
    localparam logic [AluOpBus-1:0] EXE_AND_OP   = 8'b0010_0100;
    localparam logic [AluOpBus-1:0] EXE_OR_OP    = 8'b0010_0101;
    localparam logic [AluOpBus-1:0] EXE_XOR_OP   = 8'b0010_0110;
    localparam logic [AluOpBus-1:0] EXE_NOR_OP   = 8'b0010_0111;
    localparam logic [AluOpBus-1:0] EXE_SLL_OP   = 8'b0111_1100;
    localparam logic [AluOpBus-1:0] EXE_SRL_OP   = 8'b0000_0010;
    localparam logic [AluOpBus-1:0] EXE_SRA_OP   = 8'b0000_0011;
    localparam logic [AluOpBus-1:0] EXE_MOVZ_OP  = 8'b0000_1010;
    localparam logic [AluOpBus-1:0] EXE_MOVN_OP  = 8'b0000_1011;
    localparam logic [AluOpBus-1:0] EXE_MFHI_OP  = 8'b0001_0000;
    localparam logic [AluOpBus-1:0] EXE_MTHI_OP  = 8'b0001_0001;
    localparam logic [AluOpBus-1:0] EXE_MFLO_OP  = 8'b0001_0010;
    localparam logic [AluOpBus-1:0] EXE_MTLO_OP  = 8'b0001_0011;
    localparam logic [AluOpBus-1:0] EXE_SLT_OP   = 8'b0010_1010;
    localparam logic [AluOpBus-1:0] EXE_SLTU_OP  = 8'b0010_1011;
    localparam logic [AluOpBus-1:0] EXE_ADD_OP   = 8'b0010_0000;
    localparam logic [AluOpBus-1:0] EXE_ADDU_OP  = 8'b0010_0001;
    localparam logic [AluOpBus-1:0] EXE_SUB_OP   = 8'b0010_0010;
    localparam logic [AluOpBus-1:0] EXE_SUBU_OP  = 8'b0010_0011;
    localparam logic [AluOpBus-1:0] EXE_ADDI_OP  = 8'b0101_0101;
    localparam logic [AluOpBus-1:0] EXE_ADDIU_OP = 8'b0101_0110;
    localparam logic [AluOpBus-1:0] EXE_CLZ_OP   = 8'b1011_0000;
    localparam logic [AluOpBus-1:0] EXE_CLO_OP   = 8'b1011_0001;
    localparam logic [AluOpBus-1:0] EXE_MULT_OP  = 8'b0001_1000;
    localparam logic [AluOpBus-1:0] EXE_MULTU_OP = 8'b0001_1001;
    localparam logic [AluOpBus-1:0] EXE_MUL_OP   = 8'b1010_1001;
    localparam logic [AluOpBus-1:0] EXE_MADD_OP  = 8'b1010_0110;
    localparam logic [AluOpBus-1:0] EXE_MADDU_OP = 8'b1010_1000;
    localparam logic [AluOpBus-1:0] EXE_MSUB_OP  = 8'b1010_1010;
    localparam logic [AluOpBus-1:0] EXE_MSUBU_OP = 8'b1010_1011;

    localparam logic [AluSelBus-1:0] EXE_RES_NOP        = 3'b000;
    localparam logic [AluSelBus-1:0] EXE_RES_LOGIC      = 3'b001;
    localparam logic [AluSelBus-1:0] EXE_RES_SHIFT      = 3'b010;
    localparam logic [AluSelBus-1:0] EXE_RES_MOVE       = 3'b011;
    localparam logic [AluSelBus-1:0] EXE_RES_ARITHMETIC = 3'b100;
    localparam logic [AluSelBus-1:0] EXE_RES_MUL        = 3'b101;

    typedef enum logic {ST_IDLE = 1'b0, ST_ACC = 1'b1} acc_state_t;

    // Leading-zero count, 32 for an all-zero word.
    function automatic logic [5:0] count_lead_zeros(input logic [31:0] v);
        logic [5:0] n;
        logic       done;
        n    = 6'd0;
        done = 1'b0;
        for (int i = 31; i >= 0; i--) begin
            if (!done) begin
                if (v[i]) done = 1'b1;
                else      n = n + 6'd1;
            end
        end
        return n;
    endfunction

endpackage

// File: rtl/ex_stage_mul32.sv
// Combinational 32x32 -> 64 multiplier, signed or unsigned.
module ex_stage_mul32 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        signed_i,
    output logic [63:0] product
);
    logic [63:0] ext_a;
    logic [63:0] ext_b;

    // Sign- or zero-extend to 64 bits; the low 64 bits of the product are then exact.
    always_comb begin
        ext_a   = {(signed_i ? {32{a[31]}} : 32'h0), a};
        ext_b   = {(signed_i ? {32{b[31]}} : 32'h0), b};
        product = ext_a * ext_b;
    end

endmodule

// File: rtl/ex_stage.sv
// MIPS32 execute stage: combinational ALU results plus a two-cycle
// multiply-accumulate sequence that stalls the pipeline for one cycle.
//   state   | meaning
//   IDLE    | normal single-cycle execution; MADD*/MSUB* requests a stall
//   ACC     | product captured in temp; HI/LO written with {hi,lo} + temp
module ex_stage
    import ex_stage_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic [AluOpBus-1:0]   aluop_i,
    input  logic [AluSelBus-1:0]  alusel_i,
    input  logic [RegBus-1:0]     reg1_i,
    input  logic [RegBus-1:0]     reg2_i,
    input  logic [RegAddrBus-1:0] wd_i,
    input  logic                  wreg_i,
    input  logic                  ex_hold_i,
    input  logic [RegBus-1:0]     hi_i,
    input  logic [RegBus-1:0]     lo_i,
    input  logic                  mem_whilo_i,
    input  logic [RegBus-1:0]     mem_hi_i,
    input  logic [RegBus-1:0]     mem_lo_i,
    input  logic                  wb_whilo_i,
    input  logic [RegBus-1:0]     wb_hi_i,
    input  logic [RegBus-1:0]     wb_lo_i,
    output logic [RegAddrBus-1:0] wd_o,
    output logic                  wreg_o,
    output logic [RegBus-1:0]     wdata_o,
    output logic                  whilo_o,
    output logic [RegBus-1:0]     hi_o,
    output logic [RegBus-1:0]     lo_o,
    output logic                  stallreq
);
    acc_state_t  state, state_next;
    logic [63:0] temp;
    logic [63:0] product;
    logic [63:0] acc_operand;
    logic [63:0] hilo_sum;
    logic        mul_signed, is_acc, is_msub;
    logic [RegBus-1:0] hi_cur, lo_cur;
    logic [RegBus-1:0] logic_res, shift_res, move_res, arith_res;
    logic [RegBus-1:0] b_eff, sum;
    logic        ov_op, ov;

    assign is_acc  = (aluop_i == EXE_MADD_OP) || (aluop_i == EXE_MADDU_OP) ||
                     (aluop_i == EXE_MSUB_OP) || (aluop_i == EXE_MSUBU_OP);
    assign is_msub = (aluop_i == EXE_MSUB_OP) || (aluop_i == EXE_MSUBU_OP);
    assign mul_signed = (aluop_i == EXE_MUL_OP) || (aluop_i == EXE_MULT_OP) ||
                        (aluop_i == EXE_MADD_OP) || (aluop_i == EXE_MSUB_OP);

    ex_stage_mul32 u_mul (
        .a        (reg1_i),
        .b        (reg2_i),
        .signed_i (mul_signed),
        .product  (product)
    );

    // Datapath: HI/LO forwarding and the per-class result words.
    always_comb begin
        hi_cur = mem_whilo_i ? mem_hi_i : (wb_whilo_i ? wb_hi_i : hi_i);
        lo_cur = mem_whilo_i ? mem_lo_i : (wb_whilo_i ? wb_lo_i : lo_i);

        logic_res = ZeroWord;
        case (aluop_i)
            EXE_OR_OP:  logic_res = reg1_i | reg2_i;
            EXE_AND_OP: logic_res = reg1_i & reg2_i;
            EXE_XOR_OP: logic_res = reg1_i ^ reg2_i;
            EXE_NOR_OP: logic_res = ~(reg1_i | reg2_i);
            default:    logic_res = ZeroWord;
        endcase

        shift_res = ZeroWord;
        case (aluop_i)
            EXE_SLL_OP: shift_res = reg2_i << reg1_i[4:0];
            EXE_SRL_OP: shift_res = reg2_i >> reg1_i[4:0];
            EXE_SRA_OP: shift_res = 32'($signed(reg2_i) >>> reg1_i[4:0]);
            default:    shift_res = ZeroWord;
        endcase

        move_res = ZeroWord;
        case (aluop_i)
            EXE_MFHI_OP: move_res = hi_cur;
            EXE_MFLO_OP: move_res = lo_cur;
            EXE_MOVN_OP,
            EXE_MOVZ_OP: move_res = reg1_i;
            default:     move_res = ZeroWord;
        endcase

        // Subtraction goes through the same adder so one overflow test covers ADD and SUB.
        b_eff = ((aluop_i == EXE_SUB_OP) || (aluop_i == EXE_SUBU_OP)) ? (~reg2_i + 32'd1) : reg2_i;
        sum   = reg1_i + b_eff;
        ov    = (~reg1_i[31] & ~b_eff[31] & sum[31]) | (reg1_i[31] & b_eff[31] & ~sum[31]);
        ov_op = (aluop_i == EXE_ADD_OP) || (aluop_i == EXE_ADDI_OP) || (aluop_i == EXE_SUB_OP);

        arith_res = ZeroWord;
        case (aluop_i)
            EXE_ADD_OP, EXE_ADDU_OP, EXE_ADDI_OP, EXE_ADDIU_OP,
            EXE_SUB_OP, EXE_SUBU_OP: arith_res = sum;
            EXE_SLT_OP:  arith_res = {31'd0, $signed(reg1_i) < $signed(reg2_i)};
            EXE_SLTU_OP: arith_res = {31'd0, reg1_i < reg2_i};
            EXE_CLZ_OP:  arith_res = {26'd0, count_lead_zeros(reg1_i)};
            EXE_CLO_OP:  arith_res = {26'd0, count_lead_zeros(~reg1_i)};
            default:     arith_res = ZeroWord;
        endcase

        acc_operand = is_msub ? (~product + 64'd1) : product;
        hilo_sum    = {hi_cur, lo_cur} + temp;
    end

    // State register; temp latches the (possibly negated) product on entry to ACC.
    always_ff @(posedge clk or posedge rst) begin
        if (rst == RstEnable) begin
            state <= ST_IDLE;
            temp  <= 64'd0;
        end else begin
            state <= state_next;
            if (state == ST_IDLE && is_acc) temp <= acc_operand;
        end
    end

    // Next state: ACC lasts one cycle unless the stage is held; a bubble aborts it.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: state_next = is_acc ? ST_ACC : ST_IDLE;
            ST_ACC:  state_next = (is_acc && ex_hold_i) ? ST_ACC : ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Outputs: result mux, HI/LO writes, accumulate stall; forced to zero in reset.
    always_comb begin
        wd_o     = '0;
        wreg_o   = WriteDisable;
        wdata_o  = ZeroWord;
        whilo_o  = WriteDisable;
        hi_o     = ZeroWord;
        lo_o     = ZeroWord;
        stallreq = 1'b0;
        if (rst != RstEnable) begin
            wd_o   = wd_i;
            wreg_o = wreg_i & ~(ov_op & ov);
            case (alusel_i)
                EXE_RES_LOGIC:      wdata_o = logic_res;
                EXE_RES_SHIFT:      wdata_o = shift_res;
                EXE_RES_MOVE:       wdata_o = move_res;
                EXE_RES_ARITHMETIC: wdata_o = arith_res;
                EXE_RES_MUL:        wdata_o = product[31:0];
                default:            wdata_o = ZeroWord;
            endcase
            case (aluop_i)
                EXE_MULT_OP, EXE_MULTU_OP: begin
                    whilo_o = WriteEnable;
                    hi_o    = product[63:32];
                    lo_o    = product[31:0];
                end
                EXE_MTHI_OP: begin
                    whilo_o = WriteEnable;
                    hi_o    = reg1_i;
                    lo_o    = lo_cur;
                end
                EXE_MTLO_OP: begin
                    whilo_o = WriteEnable;
                    hi_o    = hi_cur;
                    lo_o    = reg1_i;
                end
                default: ;
            endcase
            if (is_acc) begin
                if (state == ST_IDLE) begin
                    stallreq = 1'b1;
                end else begin
                    whilo_o = WriteEnable;
                    hi_o    = hilo_sum[63:32];
                    lo_o    = hilo_sum[31:0];
                end
            end
        end
    end

endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage: a vector table for single-cycle ops and
// hand sequences for forwarding, accumulate, hold and reset corners.
module tb_ex_stage;
    import ex_stage_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  aluop_i;
    logic [2:0]  alusel_i;
    logic [31:0] reg1_i, reg2_i;
    logic [4:0]  wd_i;
    logic        wreg_i, ex_hold_i;
    logic [31:0] hi_i, lo_i;
    logic        mem_whilo_i, wb_whilo_i;
    logic [31:0] mem_hi_i, mem_lo_i, wb_hi_i, wb_lo_i;
    logic [4:0]  wd_o;
    logic        wreg_o, whilo_o, stallreq;
    logic [31:0] wdata_o, hi_o, lo_o;

    int tests  = 0;
    int failed = 0;

    always #5 clk = ~clk;

    ex_stage dut (
        .clk(clk), .rst(rst), .aluop_i(aluop_i), .alusel_i(alusel_i),
        .reg1_i(reg1_i), .reg2_i(reg2_i), .wd_i(wd_i), .wreg_i(wreg_i),
        .ex_hold_i(ex_hold_i), .hi_i(hi_i), .lo_i(lo_i),
        .mem_whilo_i(mem_whilo_i), .mem_hi_i(mem_hi_i), .mem_lo_i(mem_lo_i),
        .wb_whilo_i(wb_whilo_i), .wb_hi_i(wb_hi_i), .wb_lo_i(wb_lo_i),
        .wd_o(wd_o), .wreg_o(wreg_o), .wdata_o(wdata_o), .whilo_o(whilo_o),
        .hi_o(hi_o), .lo_o(lo_o), .stallreq(stallreq)
    );

    typedef struct {
        string       name;
        logic [7:0]  op;
        logic [2:0]  sel;
        logic [31:0] r1, r2, hi, lo;
        logic        wr;
        logic        ewr;
        logic        chkd;
        logic [31:0] ed;
        logic        ewhilo;
        logic [31:0] ehi, elo;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input string n, input logic [7:0] op, input logic [2:0] sel,
                       input logic [31:0] r1, input logic [31:0] r2,
                       input logic [31:0] hi, input logic [31:0] lo, input logic wr,
                       input logic ewr, input logic chkd, input logic [31:0] ed,
                       input logic ewhilo, input logic [31:0] ehi, input logic [31:0] elo);
        vec_t v;
        v.name = n; v.op = op; v.sel = sel; v.r1 = r1; v.r2 = r2; v.hi = hi; v.lo = lo;
        v.wr = wr; v.ewr = ewr; v.chkd = chkd; v.ed = ed;
        v.ewhilo = ewhilo; v.ehi = ehi; v.elo = elo;
        vecs.push_back(v);
    endtask

    task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h expected %h", n, act, exp);
        end
    endtask

    task automatic drive(input logic [7:0] op, input logic [2:0] sel,
                         input logic [31:0] r1, input logic [31:0] r2,
                         input logic [31:0] hi, input logic [31:0] lo, input logic wr);
        aluop_i = op; alusel_i = sel; reg1_i = r1; reg2_i = r2;
        hi_i = hi; lo_i = lo; wreg_i = wr;
    endtask

    initial begin
        add("add_ovf",  EXE_ADD_OP,  EXE_RES_ARITHMETIC, 32'h7FFF_FFFF, 32'h1, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        add("addu",     EXE_ADDU_OP, EXE_RES_ARITHMETIC, 32'h7FFF_FFFF, 32'h1, 0, 0, 1, 1, 1, 32'h8000_0000, 0, 0, 0);
        add("addi_neg", EXE_ADDI_OP, EXE_RES_ARITHMETIC, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 1, 1, 1, 32'hFFFF_FFFE, 0, 0, 0);
        add("sub_ovf",  EXE_SUB_OP,  EXE_RES_ARITHMETIC, 32'h8000_0000, 32'h1, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        add("subu",     EXE_SUBU_OP, EXE_RES_ARITHMETIC, 32'h5, 32'h7, 0, 0, 1, 1, 1, 32'hFFFF_FFFE, 0, 0, 0);
        add("slt",      EXE_SLT_OP,  EXE_RES_ARITHMETIC, 32'hFFFF_FFFF, 32'h1, 0, 0, 1, 1, 1, 32'h1, 0, 0, 0);
        add("sltu",     EXE_SLTU_OP, EXE_RES_ARITHMETIC, 32'hFFFF_FFFF, 32'h1, 0, 0, 1, 1, 1, 32'h0, 0, 0, 0);
        add("clz0",     EXE_CLZ_OP,  EXE_RES_ARITHMETIC, 32'h0, 32'h0, 0, 0, 1, 1, 1, 32'd32, 0, 0, 0);
        add("clz15",    EXE_CLZ_OP,  EXE_RES_ARITHMETIC, 32'h0001_0000, 32'h0, 0, 0, 1, 1, 1, 32'd15, 0, 0, 0);
        add("clo16",    EXE_CLO_OP,  EXE_RES_ARITHMETIC, 32'hFFFF_0000, 32'h0, 0, 0, 1, 1, 1, 32'd16, 0, 0, 0);
        add("sra",      EXE_SRA_OP,  EXE_RES_SHIFT, 32'd4, 32'hF000_0000, 0, 0, 1, 1, 1, 32'hFF00_0000, 0, 0, 0);
        add("srl",      EXE_SRL_OP,  EXE_RES_SHIFT, 32'd4, 32'hF000_0000, 0, 0, 1, 1, 1, 32'h0F00_0000, 0, 0, 0);
        add("sll",      EXE_SLL_OP,  EXE_RES_SHIFT, 32'd4, 32'h0000_0F0F, 0, 0, 1, 1, 1, 32'h0000_F0F0, 0, 0, 0);
        add("sll31",    EXE_SLL_OP,  EXE_RES_SHIFT, 32'd31, 32'h3, 0, 0, 1, 1, 1, 32'h8000_0000, 0, 0, 0);
        add("or",       EXE_OR_OP,   EXE_RES_LOGIC, 32'hF0F0_00FF, 32'h0FF0_0F0F, 0, 0, 1, 1, 1, 32'hFFF0_0FFF, 0, 0, 0);
        add("and",      EXE_AND_OP,  EXE_RES_LOGIC, 32'hF0F0_00FF, 32'h0FF0_0F0F, 0, 0, 1, 1, 1, 32'h00F0_000F, 0, 0, 0);
        add("xor",      EXE_XOR_OP,  EXE_RES_LOGIC, 32'hF0F0_00FF, 32'h0FF0_0F0F, 0, 0, 1, 1, 1, 32'hFF00_0FF0, 0, 0, 0);
        add("nor",      EXE_NOR_OP,  EXE_RES_LOGIC, 32'hF0F0_00FF, 32'h0FF0_0F0F, 0, 0, 1, 1, 1, 32'h000F_F000, 0, 0, 0);
        add("mult",     EXE_MULT_OP, EXE_RES_NOP, 32'hFFFF_FFFF, 32'h2, 0, 0, 0, 0, 1, 32'h0, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        add("multu",    EXE_MULTU_OP, EXE_RES_NOP, 32'hFFFF_FFFF, 32'h2, 0, 0, 0, 0, 1, 32'h0, 1, 32'h0000_0001, 32'hFFFF_FFFE);
        add("mul",      EXE_MUL_OP,  EXE_RES_MUL, 32'hFFFF_FFFD, 32'h7, 0, 0, 1, 1, 1, 32'hFFFF_FFEB, 0, 0, 0);
        add("mthi",     EXE_MTHI_OP, EXE_RES_NOP, 32'h0000_AAAA, 32'h0, 32'h1, 32'h2, 0, 0, 1, 32'h0, 1, 32'h0000_AAAA, 32'h2);
        add("mtlo",     EXE_MTLO_OP, EXE_RES_NOP, 32'h0000_AAAA, 32'h0, 32'h1, 32'h2, 0, 0, 1, 32'h0, 1, 32'h1, 32'h0000_AAAA);
        add("mflo",     EXE_MFLO_OP, EXE_RES_MOVE, 32'h0, 32'h0, 32'h9, 32'h1234, 1, 1, 1, 32'h1234, 0, 0, 0);
        add("movn",     EXE_MOVN_OP, EXE_RES_MOVE, 32'h55, 32'h1, 0, 0, 1, 1, 1, 32'h55, 0, 0, 0);

        rst = 1'b1; ex_hold_i = 0; wd_i = 5'd7;
        mem_whilo_i = 0; mem_hi_i = 0; mem_lo_i = 0;
        wb_whilo_i = 0; wb_hi_i = 0; wb_lo_i = 0;
        drive(EXE_MULT_OP, EXE_RES_MUL, 32'h3, 32'h4, 0, 0, 1);
        #1;
        chk("rst_outs", {wd_o, wreg_o, wdata_o, whilo_o, hi_o, lo_o, stallreq} == '0, 1'b1);
        chk("rst_stall", {63'd0, stallreq}, 64'd0);
        @(negedge clk); rst = 1'b0;

        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i].op, vecs[i].sel, vecs[i].r1, vecs[i].r2, vecs[i].hi, vecs[i].lo, vecs[i].wr);
            #1;
            chk({vecs[i].name, "_wd"}, {59'd0, wd_o}, 64'd7);
            chk({vecs[i].name, "_wreg"}, {63'd0, wreg_o}, {63'd0, vecs[i].ewr});
            if (vecs[i].chkd) chk({vecs[i].name, "_wdata"}, {32'd0, wdata_o}, {32'd0, vecs[i].ed});
            chk({vecs[i].name, "_whilo"}, {62'd0, whilo_o, stallreq}, {62'd0, vecs[i].ewhilo, 1'b0});
            if (vecs[i].ewhilo) chk({vecs[i].name, "_hilo"}, {hi_o, lo_o}, {vecs[i].ehi, vecs[i].elo});
        end

        // HI forwarding priority: MEM over WB over architectural.
        @(negedge clk);
        drive(EXE_MFHI_OP, EXE_RES_MOVE, 0, 0, 32'h1, 0, 1);
        wb_whilo_i = 1; wb_hi_i = 32'h2; mem_whilo_i = 1; mem_hi_i = 32'h3;
        #1 chk("fwd_mem", {32'd0, wdata_o}, 64'd3);
        mem_whilo_i = 0;
        #1 chk("fwd_wb", {32'd0, wdata_o}, 64'd2);
        wb_whilo_i = 0;
        #1 chk("fwd_arch", {32'd0, wdata_o}, 64'd1);

        // MADD two-cycle sequence.
        @(negedge clk);
        drive(EXE_MADD_OP, EXE_RES_NOP, 32'd3, 32'd4, 32'h0, 32'h5, 0);
        #1 chk("madd_c0", {62'd0, stallreq, whilo_o}, {62'd0, 2'b10});
        @(negedge clk); #1;
        chk("madd_c1", {62'd0, stallreq, whilo_o}, {62'd0, 2'b01});
        chk("madd_hilo", {hi_o, lo_o}, {32'h0, 32'd17});
        aluop_i = EXE_NOP_OP;
        #1 chk("madd_bubble", {62'd0, stallreq, whilo_o}, 64'd0);

        // MSUBU: 5 - 12 wraps to all-ones minus 6.
        @(negedge clk);
        drive(EXE_MSUBU_OP, EXE_RES_NOP, 32'd3, 32'd4, 32'h0, 32'h5, 0);
        #1 chk("msubu_c0", {62'd0, stallreq, whilo_o}, {62'd0, 2'b10});
        @(negedge clk); #1;
        chk("msubu_c1", {62'd0, stallreq, whilo_o}, {62'd0, 2'b01});
        chk("msubu_hilo", {hi_o, lo_o}, {32'hFFFF_FFFF, 32'hFFFF_FFF9});
        aluop_i = EXE_NOP_OP;

        // Reset during ACC: outputs drop at once, FSM restarts from IDLE.
        @(negedge clk);
        drive(EXE_MADD_OP, EXE_RES_NOP, 32'd3, 32'd4, 32'h0, 32'h5, 0);
        @(negedge clk);
        rst = 1'b1;
        #1 chk("acc_rst_outs", {wd_o, wreg_o, wdata_o, whilo_o, hi_o, lo_o, stallreq} == '0, 1'b1);
        @(negedge clk);
        rst = 1'b0;
        #1 chk("acc_rst_idle", {62'd0, stallreq, whilo_o}, {62'd0, 2'b10});
        aluop_i = EXE_NOP_OP;

        // Hold in ACC for two extra cycles, then back to IDLE.
        @(negedge clk);
        drive(EXE_MADD_OP, EXE_RES_NOP, 32'd3, 32'd4, 32'h0, 32'h5, 0);
        #1 chk("hold_c0", {62'd0, stallreq, whilo_o}, {62'd0, 2'b10});
        @(negedge clk);
        ex_hold_i = 1;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("hold_ctl", {62'd0, stallreq, whilo_o}, {62'd0, 2'b01});
            chk("hold_hilo", {hi_o, lo_o}, {32'h0, 32'd17});
            if (k < 2) @(negedge clk);
        end
        ex_hold_i = 0;
        @(negedge clk);
        #1 chk("hold_release_idle", {62'd0, stallreq, whilo_o}, {62'd0, 2'b10});
        aluop_i = EXE_NOP_OP;
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
